// File: rtl/if_id_fetch_stage.sv
// Instruction fetch + IF/ID pipeline register: PC, req/ack imem handshake, redirect and stall absorption.
// Latency: IF/ID loads one edge after imem_ack_i; one instruction per cycle when ack coincides with req.
// Backpressure: a decode stall holding a live word parks the next fetched word in a hold buffer (req drops).
// Optional: define IFID_PERF_CNT_EN to add fetch_cnt_o, a saturating count of words loaded into IF/ID.
module if_id_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic [15:0] ifid_imm16_o
`ifdef IFID_PERF_CNT_EN
  ,output logic [31:0] fetch_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  // PC values are word aligned; the low two bits are forced to zero.
  localparam logic [31:0] PC_RESET_ALIGNED = PC_RESET & 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;          // redirect target saved while the old fetch drains
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic        load_vld;              // a word is offered to IF/ID this cycle
  logic [31:0] load_instr;
  logic [31:0] load_pc4;
  logic        stall_eff;
  logic [31:0] pc_plus4;
  logic [31:0] redir_tgt;

  // A stall only holds IF/ID when there is something worth holding; an empty
  // register always accepts a new word.
  assign stall_eff = stall_i & valid_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign redir_tgt = redirect_pc_i & 32'hFFFF_FFFC;

  // Fetch FSM next-state, PC update and hold-buffer/target capture.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    load_vld    = 1'b0;
    load_instr  = imem_data_i;
    load_pc4    = pc_plus4;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_i) begin
          pc_d = redir_tgt;
        end
      end
      S_REQ: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            // Word belongs to the wrong path; restart at the target.
            pc_d = redir_tgt;
          end else if (stall_eff) begin
            buf_instr_d = imem_data_i;
            buf_pc4_d   = pc_plus4;
            pc_d        = pc_plus4;
            state_d     = S_HOLD;
          end else begin
            load_vld = 1'b1;
            pc_d     = pc_plus4;
          end
        end else if (redirect_i) begin
          // The request in flight cannot be withdrawn; remember where to go.
          tgt_d   = redir_tgt;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (!stall_i) begin
          load_vld   = 1'b1;
          load_instr = buf_instr_q;
          load_pc4   = buf_pc4_q;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          tgt_d = redir_tgt;
        end
        if (imem_ack_i) begin
          pc_d    = redirect_i ? redir_tgt : tgt_q;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // IF/ID register next value: flush beats stall beats load; otherwise a bubble.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (stall_eff) begin
      valid_d = valid_q;
    end else if (load_vld) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc4_d   = load_pc4;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State, PC, hold buffer and IF/ID registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_RESET_ALIGNED;
      tgt_q       <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      valid_q     <= 1'b0;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
    end
  end

  assign imem_req_o   = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr_o  = pc_q;
  assign ifid_valid_o = valid_q;
  assign ifid_instr_o = instr_q;
  assign ifid_pc4_o   = pc4_q;
  assign ifid_imm16_o = instr_q[15:0];

`ifdef IFID_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic        cnt_inc;

  // Only words that actually land in IF/ID as valid are counted.
  assign cnt_inc = load_vld & ~flush_i & ~stall_eff;

  // Saturating delivered-word counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= 32'd0;
    end else if (cnt_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic [15:0] ifid_imm16_o;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  if_id_fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .ifid_valid_o (ifid_valid_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .ifid_imm16_o (ifid_imm16_o)
`ifdef IFID_PERF_CNT_EN
    ,.fetch_cnt_o (fetch_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack_i    = 1'b0;
    imem_data_i   = 32'd0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
  endtask

  // Reset, release, and advance through IDLE so the DUT is requesting PC 0.
  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b0;
    repeat (2) step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b0;
    #3;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr_o); end
    checks++; if ({ifid_valid_o, ifid_instr_o, ifid_pc4_o, ifid_imm16_o} !== 81'd0) begin errors++; $display("FAIL rst_ifid got v=%0b i=%h p=%h m=%h exp all 0", ifid_valid_o, ifid_instr_o, ifid_pc4_o, ifid_imm16_o); end
`ifdef IFID_PERF_CNT_EN
    checks++; if (fetch_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", fetch_cnt_o); end
`endif
    step();
    rst_i = 1'b1;
    #1;
    // First cycle out of reset is IDLE: no request yet.
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_req got %0b exp 0", imem_req_o); end
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL first_req got req=%0b addr=%h exp 1/0", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_addr_o !== 32'(4 * i) || imem_req_o !== 1'b1) begin errors++; $display("FAIL stream_addr%0d got req=%0b addr=%h exp 1/%h", i, imem_req_o, imem_addr_o, 4 * i); end
      imem_ack_i  = 1'b1;
      imem_data_i = 32'hA + 32'(i);
      step();
      checks++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'hA + 32'(i) || ifid_pc4_o !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_ifid%0d got v=%0b i=%h p=%h exp 1/%h/%h", i, ifid_valid_o, ifid_instr_o, ifid_pc4_o, 32'hA + 32'(i), 4 * i + 4); end
    end
    imem_ack_i = 1'b0;
    step();
    checks++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 32'h10) begin errors++; $display("FAIL stream_bubble got v=%0b addr=%h exp 0/10", ifid_valid_o, imem_addr_o); end
`ifdef IFID_PERF_CNT_EN
    checks++; if (fetch_cnt_o !== 32'd4) begin errors++; $display("FAIL stream_cnt got %0d exp 4", fetch_cnt_o); end
`endif
  endtask

  task automatic test_slow_ack();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL wait%0d got req=%0b addr=%h v=%0b exp 1/0/0", i, imem_req_o, imem_addr_o, ifid_valid_o); end
    end
    imem_ack_i  = 1'b1;
    imem_data_i = 32'h1234_5678;
    step();
    imem_ack_i = 1'b0;
    checks++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h1234_5678 || ifid_pc4_o !== 32'h4 || ifid_imm16_o !== 16'h5678) begin errors++; $display("FAIL slow_word got v=%0b i=%h p=%h m=%h exp 1/12345678/4/5678", ifid_valid_o, ifid_instr_o, ifid_pc4_o, ifid_imm16_o); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    imem_ack_i  = 1'b1;
    imem_data_i = 32'h0000_1111;
    step();
    stall_i     = 1'b1;
    imem_data_i = 32'h0000_2222;
    step();
    imem_ack_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL hold_req got %0b exp 0", imem_req_o); end
    checks++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h1111 || ifid_pc4_o !== 32'h4) begin errors++; $display("FAIL hold_ifid got v=%0b i=%h p=%h exp 1/1111/4", ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
    step();
    checks++; if (imem_req_o !== 1'b0 || ifid_instr_o !== 32'h1111) begin errors++; $display("FAIL hold2 got req=%0b i=%h exp 0/1111", imem_req_o, ifid_instr_o); end
    stall_i = 1'b0;
    step();
    checks++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h2222 || ifid_pc4_o !== 32'h8) begin errors++; $display("FAIL hold_release got v=%0b i=%h p=%h exp 1/2222/8", ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL hold_resume got req=%0b addr=%h exp 1/8", imem_req_o, imem_addr_o); end
`ifdef IFID_PERF_CNT_EN
    checks++; if (fetch_cnt_o !== 32'd2) begin errors++; $display("FAIL hold_cnt got %0d exp 2", fetch_cnt_o); end
`endif
  endtask

  task automatic test_redirect_drop();
    do_reset();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;   // low bits must be ignored
    step();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL drop_enter got req=%0b addr=%h v=%0b exp 1/0/0", imem_req_o, imem_addr_o, ifid_valid_o); end
    step();
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL drop_hold_addr got %h exp 0", imem_addr_o); end
    imem_ack_i  = 1'b1;
    imem_data_i = 32'hDEAD_BEEF;
    step();
    checks++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin errors++; $display("FAIL drop_discard got v=%0b addr=%h req=%0b exp 0/100/1", ifid_valid_o, imem_addr_o, imem_req_o); end
    imem_data_i = 32'h0000_0055;
    step();
    imem_ack_i = 1'b0;
    checks++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h55 || ifid_pc4_o !== 32'h104) begin errors++; $display("FAIL drop_target got v=%0b i=%h p=%h exp 1/55/104", ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
  endtask

  task automatic test_flush_wrap();
    do_reset();
    imem_ack_i  = 1'b1;
    imem_data_i = 32'h0000_0099;
    step();
    imem_ack_i = 1'b0;
    flush_i    = 1'b1;
    stall_i    = 1'b1;
    step();
    flush_i = 1'b0;
    stall_i = 1'b0;
    checks++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL flush_stall got v=%0b addr=%h exp 0/4", ifid_valid_o, imem_addr_o); end
    imem_ack_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_redir got addr=%h v=%0b exp FFFFFFFC/0", imem_addr_o, ifid_valid_o); end
    imem_data_i = 32'h0000_0077;
    step();
    imem_ack_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h0 || ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h77 || ifid_pc4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc got addr=%h v=%0b i=%h p=%h exp 0/1/77/0", imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    imem_ack_i  = 1'b1;
    imem_data_i = 32'h0000_CAFE;
    step();
    imem_ack_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || ifid_instr_o !== 32'hCAFE) begin errors++; $display("FAIL pre_rst got req=%0b addr=%h i=%h exp 1/4/CAFE", imem_req_o, imem_addr_o, ifid_instr_o); end
`ifdef IFID_PERF_CNT_EN
    checks++; if (fetch_cnt_o !== 32'd1) begin errors++; $display("FAIL pre_rst_cnt got %0d exp 1", fetch_cnt_o); end
`endif
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0 || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL async_rst got req=%0b addr=%h v=%0b i=%h p=%h exp all 0", imem_req_o, imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
`ifdef IFID_PERF_CNT_EN
    checks++; if (fetch_cnt_o !== 32'd0) begin errors++; $display("FAIL async_rst_cnt got %0d exp 0", fetch_cnt_o); end
`endif
    step();
    rst_i = 1'b1;
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL restart got req=%0b addr=%h exp 1/0", imem_req_o, imem_addr_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_slow_ack();
    test_stall_hold();
    test_redirect_drop();
    test_flush_wrap();
    test_reset_in_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
